// File: rtl/if_prefetch_queue.sv
// Prefetching instruction-fetch stage: issues sequential imem requests ahead of decode and
// buffers returned instructions in a small circular queue, with redirect flush and drop.
module if_prefetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [XLEN-1:0]        imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [XLEN-1:0]        imem_rdata,
    input  logic                   redirect,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [XLEN-1:0]        dec_pc,
    output logic [XLEN-1:0]        dec_inst,
    output logic [$clog2(DEPTH):0] q_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef logic [CntW-1:0] cnt_t;
    typedef logic [PtrW-1:0] ptr_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    ptr_t            head_q, head_d;
    ptr_t            tail_q, tail_d;
    cnt_t            count_q, count_d;
    cnt_t            out_cnt_q, out_cnt_d;
    cnt_t            drop_cnt_q, drop_cnt_d;

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];

    logic [CntW:0]   credit_used;
    logic [XLEN-1:0] target_pc;
    logic            issue;
    logic            push;
    logic            pop;
    logic            unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign target_pc           = {redirect_pc[XLEN-1:2], 2'b00};

    // Queued entries plus outstanding requests may never exceed DEPTH, so every kept
    // response is guaranteed a free slot.
    assign credit_used = {1'b0, count_q} + {1'b0, out_cnt_q};
    assign imem_req    = reset & ~redirect & (credit_used < (CntW + 1)'(DEPTH));
    assign imem_addr   = fetch_pc_q;
    assign issue       = imem_req & imem_gnt;

    assign push = imem_rvalid & ~redirect & (drop_cnt_q == '0);
    assign pop  = dec_valid & dec_ready & ~redirect;

    assign dec_valid = (count_q != '0);
    assign dec_pc    = dec_valid ? pc_mem[head_q] : '0;
    assign dec_inst  = dec_valid ? inst_mem[head_q] : '0;
    assign q_count   = count_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        out_cnt_d  = out_cnt_q + cnt_t'(issue) - cnt_t'(imem_rvalid);

        if (redirect) begin
            // Everything still in flight belongs to the old path and must be discarded.
            fetch_pc_d = target_pc;
            resp_pc_d  = target_pc;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            drop_cnt_d = out_cnt_d;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (imem_rvalid) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - cnt_t'(1);
                end else begin
                    resp_pc_d = resp_pc_q + XLEN'(4);
                end
            end
            if (push) begin
                tail_d = tail_q + ptr_t'(1);
            end
            if (pop) begin
                head_d = head_q + ptr_t'(1);
            end
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Payload storage needs no reset: outputs are gated by dec_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]   <= resp_pc_q;
            inst_mem[tail_q] <= imem_rdata;
        end
    end

    assert property (@(posedge clk) disable iff (!reset) !(push && (count_q == cnt_t'(DEPTH))));

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
- Parametrised fetch stage for the pipelined RISC-V core: replaces the single PC register + IF/ID latch with a DEPTH-entry prefetch queue.
- Issues sequential instruction-memory requests ahead of decode and tolerates any in-order memory latency ≥1 cycle.
- Supports decode back-pressure (valid/ready) and branch redirect with flush and discard of in-flight responses.
- Sits between instruction memory and the IF/ID boundary. The redirect source is the EX/MEM branch-taken logic.

Parameters:
- XLEN, 32, width of PC and instruction word.
- DEPTH, 4, queue entries and maximum outstanding requests; power of 2, ≥2.
- RESET_PC, 0, fetch address after reset.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- imem_req  output  1  request valid.
- imem_addr  output  XLEN  byte address of request, low 2 bits always 0.
- imem_gnt  input  1  memory accepts request this cycle.
- imem_rvalid  input  1  response valid; responses return in request order.
- imem_rdata  input  XLEN  instruction word.
- redirect  input  1  taken branch/jump: flush and refetch.
- redirect_pc  input  XLEN  new fetch address; bits [1:0] ignored (treated as 0).
- dec_valid  output  1  head entry valid.
- dec_ready  input  1  decode accepts head.
- dec_pc  output  XLEN  PC of head instruction.
- dec_inst  output  XLEN  head instruction.
- q_count  output  clog2(DEPTH)+1  current queue occupancy.

Behaviour:
- **Reset (reset=0, async):**
  - fetch_pc = resp_pc = RESET_PC.
  - Queue empty; out_cnt = drop_cnt = 0.
  - imem_req = 0, dec_valid = 0, dec_pc = dec_inst = 0, q_count = 0.
  - imem_addr = RESET_PC.
- **State:**
  - fetch_pc: next request address.
  - resp_pc: PC of the next kept response.
  - DEPTH-entry circular buffer of {pc, inst} with head/tail pointers and count.
  - out_cnt: requests accepted, response not yet returned.
  - drop_cnt: in-flight responses to discard.
- **Issue:**
  - imem_req = reset & ~redirect & (count + out_cnt < DEPTH).
  - imem_addr = fetch_pc.
  - On imem_req & imem_gnt: fetch_pc += 4 and out_cnt += 1.
  - imem_req is held while gnt is low; the address stays stable.
- **Response (imem_rvalid):**
  - out_cnt -= 1 in all cases.
  - If drop_cnt > 0: drop_cnt -= 1 and the data is discarded.
  - Otherwise: push {resp_pc, imem_rdata} at tail, then resp_pc += 4.
- **Credit invariant:** count + out_cnt ≤ DEPTH at all times, so a kept response never finds the queue full. A push while full is an assertion failure.
- **Output:**
  - dec_valid = (count ≠ 0); dec_pc/dec_inst are the head entry, registered (no combinational path from imem_rdata).
  - Pop on dec_valid & dec_ready.
  - Push and pop in the same cycle leave count unchanged.
- **Redirect** (takes priority over everything in that cycle):
  - No request issued that cycle.
  - Any response arriving that cycle is discarded.
  - The pop is ignored.
  - Next state: fetch_pc = resp_pc = {redirect_pc[XLEN-1:2], 2'b00}, queue emptied (count = 0), drop_cnt = out_cnt_next, where out_cnt_next is out_cnt minus any response this cycle.
  - dec_valid = 0 in the following cycle.
  - The first request to the new target issues the cycle after redirect.
- **Back-to-back redirects:** each recomputes drop_cnt from the current out_cnt; only the last target survives.
- **PC wrap:** fetch_pc/resp_pc wrap modulo 2^XLEN with no flag.
- **Latency:** with a 1-cycle memory and gnt=1:
  - Request in cycle t, response in t+1, dec_valid with that instruction in t+2.
  - DEPTH ≥ memory latency + 2 sustains 1 instruction/cycle with dec_ready=1.
- **Reset mid-operation:** everything returns to reset values immediately. Responses to pre-reset requests are the memory's responsibility: it must also be reset.

Test Plan:
- **Reset/startup.** RESET_PC=0, DEPTH=4, 1-cycle memory, gnt=1, dec_ready=1, reset released.
  - imem_addr sequence 0,4,8,... one per cycle.
  - dec_pc 0,4,8 with matching inst, first dec_valid 2 cycles after the first req.
  - Steady-state q_count ≤ 1.
- **Back-pressure.** dec_ready=0 from start.
  - Exactly 4 requests issued (0x0..0xC); q_count reaches 4; imem_req stays 0.
  - Then dec_ready=1: pops in order 0x0,0x4,0x8,0xC; fetch resumes at 0x10.
- **Redirect with in-flight responses.** 3-cycle memory, 3 requests outstanding, redirect_pc=0x103.
  - 3 responses dropped; next imem_addr=0x100.
  - First dec_pc after redirect = 0x100; no stale PCs seen by decode.
- **Simultaneous events.** Redirect in the same cycle as imem_rvalid and a dec_valid&dec_ready pop.
  - That response is not enqueued; count=0 next cycle.
  - drop_cnt equals remaining in-flight count.
- **Grant stall.** imem_gnt=0 for 5 cycles.
  - imem_req=1 and imem_addr constant (e.g. 0x20) throughout; fetch_pc advances only on the gnt=1 cycle.
- **Async reset mid-run.** reset pulsed low between clock edges with q_count=3.
  - Outputs zero immediately (dec_valid=0, imem_req=0).
  - After release, fetch restarts at RESET_PC.
